id_scoreboard_rf: RTL



---
 rtl/id_scoreboard_rf.sv | 95 +++++++++
 1 files changed

// File: rtl/id_scoreboard_rf.sv
// ID-stage register file with a per-register load-latency scoreboard.
// Raises Stall while a source operand waits on an in-flight load.
module id_scoreboard_rf #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 1,
  parameter int STATW    = 16,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(LOAD_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1Addr,
  input  logic [AW-1:0]    rs2Addr,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  output logic [XLEN-1:0]  rs1Data,
  output logic [XLEN-1:0]  rs2Data,
  input  logic             RegWrite_wb,
  input  logic [AW-1:0]    rdAddr_wb,
  input  logic [XLEN-1:0]  RegWriteData_wb,
  input  logic             issue_valid,
  input  logic             issue_load,
  input  logic [AW-1:0]    issue_rd,
  input  logic             flush,
  output logic             Stall,
  output logic             IFWrite,
  output logic [STATW-1:0] stall_cycles
);

  logic [XLEN-1:0]  r_rf  [NREG];
  logic [CW-1:0]    r_cnt [NREG];
  logic [STATW-1:0] r_stat;

  logic w_we;
  logic w_busy1;
  logic w_busy2;
  logic w_stall;
  logic w_set;

  assign w_we = RegWrite_wb & (rdAddr_wb != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_we) begin
      r_rf[rdAddr_wb] <= RegWriteData_wb;
    end
  end

  // write-back in the same cycle is forwarded to the reader
  always_comb begin
    rs1Data = r_rf[rs1Addr];
    rs2Data = r_rf[rs2Addr];
    if (w_we && rdAddr_wb == rs1Addr) rs1Data = RegWriteData_wb;
    if (w_we && rdAddr_wb == rs2Addr) rs2Data = RegWriteData_wb;
    if (rs1Addr == '0) rs1Data = '0;
    if (rs2Addr == '0) rs2Data = '0;
  end

  assign w_busy1 = uses_rs1 & (rs1Addr != '0) & (r_cnt[rs1Addr] != '0);
  assign w_busy2 = uses_rs2 & (rs2Addr != '0) & (r_cnt[rs2Addr] != '0);
  assign w_stall = issue_valid & ~flush & (w_busy1 | w_busy2);

  assign Stall   = w_stall;
  assign IFWrite = ~w_stall;

  assign w_set = issue_valid & ~w_stall & ~flush
               & issue_load & (issue_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_set && issue_rd == AW'(i))
          r_cnt[i] <= CW'(LOAD_LAT);
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stat <= '0;
    else if (w_stall && r_stat != '1)
      r_stat <= r_stat + STATW'(1);
  end

  assign stall_cycles = r_stat;

endmodule
